uart_core: RTL

- Byte-wide serial transceiver directly downstream of the memory-mapped peripheral block. It converts the peripheral's parallel tx_data/tx_enable into an 8N1 serial stream on PC_Uart_txd.
- It deserialises PC_Uart_rxd into rx_data with a completion status.
- Single clock domain (sysclk). The only asynchronous input is PC_Uart_rxd.
- Internal 16x oversampling tick drives both directions.

---
 rtl/uart_core.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core.sv
// 8N1 UART transceiver (8E1 when UART_PARITY_EN is defined) with a shared 16x oversample tick.
// TX accepts one byte per frame in TX_IDLE only; RX reports the byte via rx_status/rx_data or pulses frame_err.
module uart_core #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    input  logic       rx_enable,
    output logic       tx_status,
    output logic       rx_status,
    output logic [7:0] rx_data,
    output logic       frame_err,
    input  logic       PC_Uart_rxd,
    output logic       PC_Uart_txd
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

    // ------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    assign tick       = (tick_cnt_q == CW'(DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t  tx_state_q;
    logic [3:0] tx_ph_q;
    logic [2:0] tx_bit_q;
    logic [7:0] tx_shift_q;
    logic       txd_q;
    logic       tx_status_q;
`ifdef UART_PARITY_EN
    logic       tx_par_q;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            tx_ph_q     <= 4'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            txd_q       <= 1'b1;
            tx_status_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q    <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_enable) begin
                        tx_shift_q  <= tx_data;
                        tx_status_q <= 1'b0;
                        txd_q       <= 1'b0;
                        tx_ph_q     <= 4'd0;
                        tx_bit_q    <= 3'd0;
                        tx_state_q  <= TX_START;
`ifdef UART_PARITY_EN
                        tx_par_q    <= ^tx_data;
`endif
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_ph_q <= tx_ph_q + 4'd1;
                        if (tx_ph_q == 4'd15) begin
                            txd_q      <= tx_shift_q[0];
                            tx_state_q <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        tx_ph_q <= tx_ph_q + 4'd1;
                        if (tx_ph_q == 4'd15) begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                txd_q      <= tx_par_q;
                                tx_state_q <= TX_PARITY;
`else
                                txd_q      <= 1'b1;
                                tx_state_q <= TX_STOP;
`endif
                            end else begin
                                // Next bit is the one about to become shift[0].
                                txd_q <= tx_shift_q[1];
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        tx_ph_q <= tx_ph_q + 4'd1;
                        if (tx_ph_q == 4'd15) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end
                    end
                end
`endif
                TX_STOP: begin
                    if (tick) begin
                        tx_ph_q <= tx_ph_q + 4'd1;
                        if (tx_ph_q == 4'd15) begin
                            tx_status_q <= 1'b1;
                            tx_state_q  <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    txd_q       <= 1'b1;
                    tx_status_q <= 1'b1;
                    tx_state_q  <= TX_IDLE;
                end
            endcase
        end
    end

    assign PC_Uart_txd = txd_q;
    assign tx_status   = tx_status_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= PC_Uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    rx_state_t  rx_state_q;
    logic [3:0] rx_ph_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_status_q;
    logic       frame_err_q;
    logic       rx_frame_ok;
`ifdef UART_PARITY_EN
    logic       rx_par_err_q;

    assign rx_frame_ok = rxd_sync_q & ~rx_par_err_q;
`else
    assign rx_frame_ok = rxd_sync_q;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            rx_ph_q      <= 4'd0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_status_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // A real falling edge is required, so a line stuck low cannot retrigger.
                    if (rx_enable && rxd_prev_q && !rxd_sync_q) begin
                        rx_status_q <= 1'b0;
                        rx_ph_q     <= 4'd0;
                        rx_state_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_ph_q <= rx_ph_q + 4'd1;
                        if (rx_ph_q == 4'd7) begin
                            rx_ph_q  <= 4'd0;
                            rx_bit_q <= 3'd0;
                            rx_state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_ph_q <= rx_ph_q + 4'd1;
                        if (rx_ph_q == 4'd15) begin
                            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                rx_state_q <= RX_PARITY;
`else
                                rx_state_q <= RX_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        rx_ph_q <= rx_ph_q + 4'd1;
                        if (rx_ph_q == 4'd15) begin
                            rx_par_err_q <= rxd_sync_q ^ (^rx_shift_q);
                            rx_state_q   <= RX_STOP;
                        end
                    end
                end
`endif
                RX_STOP: begin
                    if (tick) begin
                        rx_ph_q <= rx_ph_q + 4'd1;
                        if (rx_ph_q == 4'd15) begin
                            rx_state_q <= RX_IDLE;
                            if (rx_frame_ok) begin
                                rx_data_q   <= rx_shift_q;
                                rx_status_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign frame_err = frame_err_q;

endmodule
